// File: rtl/gptp_rtc_updater.sv
// Update initiator for the rtc: turns servo/firmware time-correction commands into
// single-strobe base-time, offset or rate updates on the rtc update interface.
//
// state    | meaning
// ---------+--------------------------------------------------------------
// IDLE     | waiting for a command; rate and reserved commands finish here
// NORM     | folding whole seconds out of w_ns into {w_ep, w_sec}
// WAIT_RDY | waiting for rtc_ready, bounded by the timeout down-counter
// ISSUE    | one-cycle gptp_vaild strobe with fields loaded
module gptp_rtc_updater #(
    parameter logic [25:0] INC_NOMINAL = 26'h0800000,
    parameter logic [25:0] INC_MIN     = 26'h0700000,
    parameter logic [25:0] INC_MAX     = 26'h0900000,
    parameter logic [31:0] NS_PER_SEC  = 32'd1000000000,
    parameter int          TIMEOUT_CYC = 1024
) (
    input  logic        rtc_clk,
    input  logic        rtc_reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_type,
    input  logic [15:0] cmd_epoch,
    input  logic [31:0] cmd_sec,
    input  logic [31:0] cmd_nanosec,
    input  logic [25:0] cmd_increment,
    input  logic        rtc_ready,
    output logic        gptp_vaild,
    output logic        gptp_sw,
    output logic [31:0] syntonised_nanosec_field_r,
    output logic [31:0] syntonised_sec_field_r,
    output logic [15:0] syntonised_epoch_field_r,
    output logic [29:0] nanosec_offset,
    output logic [31:0] sec_offset,
    output logic [15:0] epoch_offset,
    output logic [25:0] rtc_increment,
    output logic        upd_busy,
    output logic        upd_timeout
);

    localparam int             CNT_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(TIMEOUT_CYC - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_NORM,
        S_WAIT_RDY,
        S_ISSUE
    } state_t;

    state_t state, state_nxt;

    logic             w_is_offset;
    logic [15:0]      w_ep;
    logic [31:0]      w_sec;
    logic [31:0]      w_ns;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             ns_over;
    logic             wait_done;
    logic [25:0]      inc_clamped;

    assign accept    = cmd_valid && cmd_ready;
    assign ns_over   = (w_ns >= NS_PER_SEC);
    assign wait_done = (wait_cnt == '0);

    always_comb begin
        inc_clamped = cmd_increment;
        if (cmd_increment < INC_MIN) begin
            inc_clamped = INC_MIN;
        end else if (cmd_increment > INC_MAX) begin
            inc_clamped = INC_MAX;
        end
    end

    always_ff @(posedge rtc_clk or negedge rtc_reset) begin
        if (!rtc_reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (accept && !cmd_type[1]) begin
                    state_nxt = S_NORM;
                end
            end
            S_NORM: begin
                if (!ns_over) begin
                    state_nxt = S_WAIT_RDY;
                end
            end
            S_WAIT_RDY: begin
                if (rtc_ready) begin
                    state_nxt = S_ISSUE;
                end else if (wait_done) begin
                    state_nxt = S_IDLE;
                end
            end
            S_ISSUE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge rtc_clk or negedge rtc_reset) begin
        if (!rtc_reset) begin
            cmd_ready                  <= 1'b1;
            upd_busy                   <= 1'b0;
            gptp_vaild                 <= 1'b0;
            gptp_sw                    <= 1'b1;
            upd_timeout                <= 1'b0;
            rtc_increment              <= INC_NOMINAL;
            syntonised_nanosec_field_r <= '0;
            syntonised_sec_field_r     <= '0;
            syntonised_epoch_field_r   <= '0;
            nanosec_offset             <= '0;
            sec_offset                 <= '0;
            epoch_offset               <= '0;
            w_is_offset                <= 1'b0;
            w_ep                       <= '0;
            w_sec                      <= '0;
            w_ns                       <= '0;
            wait_cnt                   <= '0;
        end else begin
            cmd_ready  <= (state_nxt == S_IDLE);
            upd_busy   <= (state_nxt != S_IDLE);
            gptp_vaild <= (state_nxt == S_ISSUE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        if (!cmd_type[1]) begin
                            w_is_offset <= cmd_type[0];
                            w_ep        <= cmd_epoch;
                            w_sec       <= cmd_sec;
                            w_ns        <= cmd_nanosec;
                            upd_timeout <= 1'b0;
                        end else if (!cmd_type[0]) begin
                            rtc_increment <= inc_clamped;
                        end
                    end
                end
                S_NORM: begin
                    if (ns_over) begin
                        w_ns          <= w_ns - NS_PER_SEC;
                        {w_ep, w_sec} <= {w_ep, w_sec} + 48'd1;
                    end else begin
                        wait_cnt <= CNT_LOAD;
                    end
                end
                S_WAIT_RDY: begin
                    if (rtc_ready) begin
                        gptp_sw <= w_is_offset;
                        if (w_is_offset) begin
                            epoch_offset   <= w_ep;
                            sec_offset     <= w_sec;
                            nanosec_offset <= w_ns[29:0];
                        end else begin
                            syntonised_epoch_field_r   <= w_ep;
                            syntonised_sec_field_r     <= w_sec;
                            syntonised_nanosec_field_r <= w_ns;
                        end
                    end else if (wait_done) begin
                        upd_timeout <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                S_ISSUE: begin
                    // Offsets are one-shot so the rtc can never apply a step twice.
                    gptp_sw        <= 1'b1;
                    epoch_offset   <= '0;
                    sec_offset     <= '0;
                    nanosec_offset <= '0;
                end
                default: begin
                    gptp_sw <= 1'b1;
                end
            endcase
        end
    end

endmodule
